// File: rtl/dbg_pkg.sv
// dbg_pkg: shared definitions for the debug-access unit.
//   - opcode encodings carried on i_cmd_op
//   - controller state encoding
//   - default widths and halt timeout
//   - helper to classify ops that need the core stopped
package dbg_pkg;

  localparam int XLEN_DEF         = 64;
  localparam int PC_W_DEF         = 32;
  localparam int HALT_TIMEOUT_DEF = 16;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_RD_REG = 3'd1;
  localparam logic [2:0] OP_WR_REG = 3'd2;
  localparam logic [2:0] OP_RD_PC  = 3'd3;
  localparam logic [2:0] OP_WR_PC  = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd5;
  localparam logic [2:0] OP_RESUME = 3'd6;
  localparam logic [2:0] OP_RSV    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HALT = 2'd1,
    ST_ACCESS    = 2'd2,
    ST_RESP      = 2'd3
  } dbg_state_e;

  // Ops that touch core state and therefore need the core stopped first.
  function automatic logic is_halting_op(input logic [2:0] op);
    return (op == OP_RD_REG) || (op == OP_WR_REG) || (op == OP_RD_PC) ||
           (op == OP_WR_PC)  || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/dbg_timeout_ctr.sv
// dbg_timeout_ctr: halt-wait timer, a down-counter with terminal-count compare.
//   i_clk       system clock
//   i_reset     synchronous active-high reset (counter -> 0)
//   i_load      restart the timer (loads HALT_TIMEOUT-1)
//   i_en        count down one step this cycle
//   o_expired   counter sits at terminal count (0)
// Loading HALT_TIMEOUT-1 and expiring at 0 gives exactly HALT_TIMEOUT
// enabled cycles before o_expired is acted on.
module dbg_timeout_ctr import dbg_pkg::*; #(
  parameter int HALT_TIMEOUT = HALT_TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(HALT_TIMEOUT - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/dbg_access_unit.sv
// dbg_access_unit: debug-access port for the sequential RISC-V core.
// A host sends one command at a time; the unit halts the core when needed,
// reads/writes the register file or PC, and returns one response.
//
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready         command handshake
//   i_cmd_op/i_cmd_addr/i_cmd_wdata command fields
//   o_rsp_valid/i_rsp_ready         response handshake
//   o_rsp_data/o_rsp_err            response payload
//   o_core_halt_req/i_core_halted   halt request / core stopped
//   o_rf_raddr/i_rf_rdata           combinational register-file debug read
//   o_rf_we/o_rf_waddr/o_rf_wdata   register-file debug write
//   i_pc_rdata                      current PC
//   o_pc_we/o_pc_wdata              PC load
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | ready for a command; halt_req follows sticky_halt
// WAIT_HALT  | halt_req asserted, waiting for core_halted or timeout
// ACCESS     | single cycle: register/PC access strobes are live
// RESP       | response held until the host takes it
module dbg_access_unit import dbg_pkg::*; #(
  parameter int XLEN         = XLEN_DEF,
  parameter int PC_W         = PC_W_DEF,
  parameter int HALT_TIMEOUT = HALT_TIMEOUT_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [2:0]      i_cmd_op,
  input  logic [4:0]      i_cmd_addr,
  input  logic [XLEN-1:0] i_cmd_wdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_rsp_err,
  output logic            o_core_halt_req,
  input  logic            i_core_halted,
  output logic [4:0]      o_rf_raddr,
  input  logic [XLEN-1:0] i_rf_rdata,
  output logic            o_rf_we,
  output logic [4:0]      o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata,
  input  logic [PC_W-1:0] i_pc_rdata,
  output logic            o_pc_we,
  output logic [PC_W-1:0] o_pc_wdata
);

  dbg_state_e      r_state;
  logic [2:0]      r_op;
  logic [4:0]      r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_sticky_halt;

  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_rsp_err;
  logic            r_halt_req;
  logic [4:0]      r_rf_raddr;
  logic            r_rf_we;
  logic [4:0]      r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;
  logic            r_pc_we;
  logic [PC_W-1:0] r_pc_wdata;

  logic            w_cmd_fire;
  logic            w_tmo_en;
  logic            w_tmo_expired;

  assign w_cmd_fire = i_cmd_valid && (r_state == ST_IDLE);
  assign w_tmo_en   = (r_state == ST_WAIT_HALT) && !i_core_halted;

  dbg_timeout_ctr #(
    .HALT_TIMEOUT (HALT_TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_cmd_fire),
    .i_en      (w_tmo_en),
    .o_expired (w_tmo_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_NOP;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_sticky_halt <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_halt_req    <= 1'b0;
      r_rf_raddr    <= '0;
      r_rf_we       <= 1'b0;
      r_rf_waddr    <= '0;
      r_rf_wdata    <= '0;
      r_pc_we       <= 1'b0;
      r_pc_wdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_op       <= i_cmd_op;
            r_addr     <= i_cmd_addr;
            r_wdata    <= i_cmd_wdata;
            r_rsp_data <= '0;
            r_rsp_err  <= (i_cmd_op == OP_RSV);
            if (is_halting_op(i_cmd_op)) begin
              r_halt_req <= 1'b1;
              r_state    <= ST_WAIT_HALT;
            end else begin
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
              // RESUME releases the core right away, not at response accept.
              if (i_cmd_op == OP_RESUME) begin
                r_sticky_halt <= 1'b0;
                r_halt_req    <= 1'b0;
              end
            end
          end
        end

        ST_WAIT_HALT: begin
          // A halted core wins over a timeout landing on the same cycle.
          if (i_core_halted) begin
            r_state    <= ST_ACCESS;
            r_rf_raddr <= (r_op == OP_RD_REG) ? r_addr : 5'd0;
            r_rf_we    <= (r_op == OP_WR_REG) && (r_addr != 5'd0);
            r_pc_we    <= (r_op == OP_WR_PC);
            if (r_op == OP_WR_REG) begin
              r_rf_waddr <= r_addr;
              r_rf_wdata <= r_wdata;
            end
            if (r_op == OP_WR_PC) begin
              r_pc_wdata <= r_wdata[PC_W-1:0];
            end
          end else if (w_tmo_expired) begin
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end

        ST_ACCESS: begin
          r_rf_we    <= 1'b0;
          r_pc_we    <= 1'b0;
          r_rf_raddr <= 5'd0;
          case (r_op)
            OP_RD_REG: r_rsp_data <= (r_addr == 5'd0) ? '0 : i_rf_rdata;
            OP_RD_PC:  r_rsp_data <= {{(XLEN-PC_W){1'b0}}, i_pc_rdata};
            OP_HALT:   r_sticky_halt <= 1'b1;
            default:   ;
          endcase
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end

        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_halt_req  <= r_sticky_halt;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready     = (r_state == ST_IDLE);
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_data      = r_rsp_data;
  assign o_rsp_err       = r_rsp_err;
  assign o_core_halt_req = r_halt_req;
  assign o_rf_raddr      = r_rf_raddr;
  assign o_rf_we         = r_rf_we;
  assign o_rf_waddr      = r_rf_waddr;
  assign o_rf_wdata      = r_rf_wdata;
  assign o_pc_we         = r_pc_we;
  assign o_pc_wdata      = r_pc_wdata;

endmodule

// File: tb/tb_dbg_access_unit.sv
// tb_dbg_access_unit: directed scenarios plus random command traffic against
// a transaction-level model (register array, PC value, sticky-halt flag).
module tb_dbg_access_unit;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        core_halt_req;
  logic        core_halted;
  logic [4:0]  rf_raddr;
  logic [63:0] rf_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] pc_rdata;
  logic        pc_we;
  logic [31:0] pc_wdata;

  logic        core_ok;
  logic [63:0] env_rf [0:31];
  logic [31:0] env_pc;

  logic [63:0] ref_rf [0:31];
  logic [31:0] ref_pc;
  logic        ref_sticky;

  int n_checks;
  int n_errors;

  dbg_access_unit u_dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_op        (cmd_op),
    .i_cmd_addr      (cmd_addr),
    .i_cmd_wdata     (cmd_wdata),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_data      (rsp_data),
    .o_rsp_err       (rsp_err),
    .o_core_halt_req (core_halt_req),
    .i_core_halted   (core_halted),
    .o_rf_raddr      (rf_raddr),
    .i_rf_rdata      (rf_rdata),
    .o_rf_we         (rf_we),
    .o_rf_waddr      (rf_waddr),
    .o_rf_wdata      (rf_wdata),
    .i_pc_rdata      (pc_rdata),
    .o_pc_we         (pc_we),
    .o_pc_wdata      (pc_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core environment: halts as soon as asked when responsive.
  assign core_halted = core_ok & core_halt_req;
  assign rf_rdata    = env_rf[rf_raddr];
  assign pc_rdata    = env_pc;

  always @(posedge clk) begin
    if (rf_we) env_rf[rf_waddr] <= rf_wdata;
    if (pc_we) env_pc <= pc_wdata;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    check_val("rst_cmd_ready", cmd_ready, 1);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    check_val("rst_rsp_err", rsp_err, 0);
    check_val("rst_halt_req", core_halt_req, 0);
    check_val("rst_rf_we", rf_we, 0);
    check_val("rst_pc_we", pc_we, 0);
    check_val("rst_rf_raddr", rf_raddr, 0);
    check_val("rst_rf_waddr", rf_waddr, 0);
    check_val("rst_rf_wdata", rf_wdata, 0);
    check_val("rst_pc_wdata", pc_wdata, 0);
  endtask

  // Issues one command starting from a negedge, follows it to response
  // acceptance, and returns positioned at the negedge after the handshake.
  task automatic run_cmd(input logic [2:0] op, input logic [4:0] addr,
                         input logic [63:0] wdata, input int bp_cycles);
    logic        halting;
    logic        tmo;
    int          exp_lat;
    logic        exp_err;
    logic [63:0] exp_data;
    int          exp_rfwe;
    int          exp_pcwe;
    logic        exp_req1;
    int          lat;
    int          n_rfwe;
    int          n_pcwe;

    halting  = (op >= 3'd1) && (op <= 3'd5);
    tmo      = halting && !core_ok;
    exp_lat  = !halting ? 1 : (tmo ? 17 : 3);
    exp_err  = (op == 3'd7) || tmo;
    exp_data = 64'd0;
    if (!tmo && op == 3'd1) exp_data = (addr == 5'd0) ? 64'd0 : ref_rf[addr];
    if (!tmo && op == 3'd3) exp_data = {32'd0, ref_pc};
    exp_rfwe = (op == 3'd2 && addr != 5'd0 && !tmo) ? 1 : 0;
    exp_pcwe = (op == 3'd4 && !tmo) ? 1 : 0;
    exp_req1 = halting ? 1'b1 : ((op == 3'd6) ? 1'b0 : ref_sticky);

    check_val("idle_cmd_ready", cmd_ready, 1);
    check_val("idle_halt_req", core_halt_req, ref_sticky);

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(posedge clk);
    lat    = 0;
    n_rfwe = 0;
    n_pcwe = 0;
    while (1) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat++;
      if (lat == 1) begin
        check_val("busy_cmd_ready", cmd_ready, 0);
        check_val("halt_req_after_accept", core_halt_req, exp_req1);
      end
      if (rf_we) begin
        n_rfwe++;
        check_val("rf_waddr", rf_waddr, addr);
        check_val("rf_wdata", rf_wdata, wdata);
      end
      if (pc_we) begin
        n_pcwe++;
        check_val("pc_wdata", pc_wdata, {32'd0, wdata[31:0]});
      end
      if (rsp_valid) break;
      if (lat > 40) break;
    end
    check_val("rsp_latency", lat, exp_lat);
    check_val("rsp_err", rsp_err, exp_err);
    check_val("rsp_data", rsp_data, exp_data);

    for (int i = 0; i < bp_cycles; i++) begin
      @(negedge clk);
      check_val("bp_rsp_valid", rsp_valid, 1);
      check_val("bp_rsp_data", rsp_data, exp_data);
      check_val("bp_cmd_ready", cmd_ready, 0);
      if (rf_we) n_rfwe++;
      if (pc_we) n_pcwe++;
    end

    if (!tmo && op == 3'd2 && addr != 5'd0) ref_rf[addr] = wdata;
    if (!tmo && op == 3'd4) ref_pc = wdata[31:0];
    if (!tmo && op == 3'd5) ref_sticky = 1'b1;
    if (op == 3'd6) ref_sticky = 1'b0;

    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rf_we) n_rfwe++;
    if (pc_we) n_pcwe++;
    check_val("rsp_valid_drop", rsp_valid, 0);
    check_val("halt_req_after_rsp", core_halt_req, ref_sticky);
    check_val("rf_we_pulses", n_rfwe, exp_rfwe);
    check_val("pc_we_pulses", n_pcwe, exp_pcwe);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    logic [2:0]  rop;
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 3'd0;
    cmd_addr   = 5'd0;
    cmd_wdata  = 64'd0;
    rsp_ready  = 1'b0;
    core_ok    = 1'b1;
    ref_sticky = 1'b0;
    for (int i = 0; i < 32; i++) begin
      v = {$urandom, $urandom};
      env_rf[i] = v;
      ref_rf[i] = v;
    end
    env_rf[0] = 64'h1234;
    ref_rf[0] = 64'h1234;
    env_pc = 32'h8;
    ref_pc = 32'h8;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_state();

    run_cmd(3'd2, 5'd2, 64'h10, 0);
    run_cmd(3'd1, 5'd2, 64'h0, 0);
    run_cmd(3'd2, 5'd0, 64'hFFFF, 0);
    run_cmd(3'd1, 5'd0, 64'h0, 0);
    run_cmd(3'd3, 5'd0, 64'h0, 0);
    run_cmd(3'd4, 5'd0, 64'h100, 0);
    run_cmd(3'd3, 5'd0, 64'h0, 1);
    core_ok = 1'b0;
    run_cmd(3'd1, 5'd5, 64'h0, 0);
    run_cmd(3'd2, 5'd3, 64'hDEAD_BEEF, 0);
    core_ok = 1'b1;
    run_cmd(3'd5, 5'd0, 64'h0, 0);
    run_cmd(3'd1, 5'd1, 64'h0, 0);
    run_cmd(3'd6, 5'd0, 64'h0, 0);
    run_cmd(3'd1, 5'd4, 64'h0, 5);
    run_cmd(3'd7, 5'd9, 64'h55, 2);
    run_cmd(3'd0, 5'd0, 64'h0, 0);

    // Reset while waiting for a halt that never comes; a command presented
    // during the reset cycle must be dropped.
    core_ok   = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_addr  = 5'd6;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    ref_sticky = 1'b0;
    check_reset_state();
    repeat (4) @(negedge clk);
    check_val("post_reset_no_rsp", rsp_valid, 0);
    check_val("post_reset_no_req", core_halt_req, 0);
    core_ok = 1'b1;

    for (int n = 0; n < 150; n++) begin
      rop     = 3'($urandom_range(0, 7));
      core_ok = ($urandom_range(0, 5) != 0);
      v       = {$urandom, $urandom};
      run_cmd(rop, 5'($urandom_range(0, 31)), v, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dbg_access_unit.md
Name: dbg_access_unit

Overview:
- Hardware debug-access port for the sequential RISC-V core; the synthesizable counterpart to bench-side register/PC poking.
- An external host issues commands over a valid/ready channel. The block halts the core, reads or writes the register file or PC, and returns one response per command.
- Sits beside `processor` and drives the register file's debug read/write ports, the PC-load port and the halt request.

Parameters:
- XLEN, 64, register-file data width.
- PC_W, 32, program-counter width.
- HALT_TIMEOUT, 16, cycles to wait for `core_halted` before aborting with error.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  block accepts command
- cmd_op  in  3  opcode: 0 NOP, 1 RD_REG, 2 WR_REG, 3 RD_PC, 4 WR_PC, 5 HALT, 6 RESUME, 7 reserved
- cmd_addr  in  5  register index
- cmd_wdata  in  XLEN  write data; PC ops use [PC_W-1:0]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  XLEN  read data, zero for non-read ops
- rsp_err  out  1  command failed
- core_halt_req  out  1  request core to stop at instruction boundary
- core_halted  in  1  core is stopped
- rf_raddr  out  5  debug read index; register file read is combinational
- rf_rdata  in  XLEN  debug read data
- rf_we  out  1  debug write strobe
- rf_waddr  out  5  debug write index
- rf_wdata  out  XLEN  debug write data
- pc_rdata  in  PC_W  current PC
- pc_we  out  1  PC load strobe
- pc_wdata  out  PC_W  PC load value

Behaviour:
- Reset: all outputs 0, state IDLE, sticky_halt=0, timeout counter 0. A reset mid-operation abandons the command with no response; a pending strobe never fires after reset.
- States: IDLE, WAIT_HALT, ACCESS, RESP.
- IDLE:
  - cmd_ready=1; handshake is cmd_valid&cmd_ready.
  - On accept: latch op/addr/wdata, clear the timeout counter.
  - NOP, op 7 and RESUME go directly to RESP. RESUME clears sticky_halt.
  - All other ops assert core_halt_req and go to WAIT_HALT.
- WAIT_HALT:
  - core_halt_req held; counter increments each cycle.
  - When core_halted=1, go to ACCESS.
  - When the counter reaches HALT_TIMEOUT with core_halted still 0, go to RESP with rsp_err=1; no register or PC access occurs.
- ACCESS (exactly one cycle):
  - RD_REG: rf_raddr=addr; rsp_data<=rf_rdata. Index 0 returns 0 regardless of rf_rdata.
  - WR_REG: rf_we=1 for one cycle with waddr/wdata, except when addr==0 (no strobe, rsp_err=0).
  - RD_PC: rsp_data<={zero-extend, pc_rdata}.
  - WR_PC: pc_we=1 for one cycle, pc_wdata=wdata[PC_W-1:0].
  - HALT: sets sticky_halt.
  - Then go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err stay stable until rsp_ready.
  - rsp_err=1 for op 7 or halt timeout; otherwise 0.
  - On rsp_valid&rsp_ready: go to IDLE. core_halt_req drops the same cycle unless sticky_halt=1.
- Latency, command accept to rsp_valid, with core_halted already 1:
  - Halting ops (RD_REG, WR_REG, RD_PC, WR_PC, HALT): 3 cycles (accept -> WAIT_HALT -> ACCESS -> RESP).
  - NOP, RESUME, op 7: 1 cycle.
- Single outstanding command; cmd_ready=0 outside IDLE.
- A response may be accepted and a new command accepted in the next cycle, i.e. no overlap.
- core_halt_req stays high continuously while sticky_halt=1, including in IDLE.
- When sticky_halt=1, WAIT_HALT completes on the first cycle core_halted is seen.
- A command arriving the same cycle as reset is ignored.

Decomposition:
- Package `dbg_pkg`:
  - opcode localparams OP_NOP..OP_RSV;
  - state encoding constants;
  - the XLEN/PC_W defaults.
- No sub-module is required. Optionally factor the timeout counter as `dbg_timeout_ctr` (load/enable/expire); otherwise keep it inline.

Test Plan:
- WR_REG addr=2 wdata=0x10 with core_halted tied high:
  - one-cycle rf_we, waddr=2, wdata=0x10;
  - rsp_valid 3 cycles after accept, rsp_err=0.
  - Then RD_REG addr=2 with rf_rdata model -> rsp_data=0x10.
- WR_REG addr=0 wdata=0xFFFF -> rf_we never asserts, rsp_err=0. RD_REG addr=0 with rf_rdata=0x1234 -> rsp_data=0.
- RD_PC with pc_rdata=0x00000008 -> rsp_data=0x8. WR_PC wdata=0x100 -> pc_we one cycle, pc_wdata=0x100.
- core_halted held 0 -> after 16 WAIT_HALT cycles, rsp_valid=1, rsp_err=1, no rf_we/pc_we, core_halt_req drops on response accept.
- HALT then RD_REG x1 -> core_halt_req stays 1 through both; RESUME -> core_halt_req 0 one cycle after RESUME is accepted.
- Backpressure and reset:
  - rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0.
  - Assert reset in WAIT_HALT -> next cycle all outputs 0, cmd_ready=1.
- op=7 -> rsp_valid 1 cycle after accept, rsp_err=1, core_halt_req never asserted.
